uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Transmit side of the UART link: serializes one parallel byte into a frame on tx_out.
//  Frame = start(0), DATA_WIDTH data bits LSB first, optional parity, one stop(1).
//  Integrated FSM, bit/edge counters, parity generator and serializer; each bit lasts `prescale` clks.
//  Sits between the host-side byte source and the serial pin; line format matches the RX path.
// PARAMETERS
//  DATA_WIDTH  8  number of data bits per frame
//  PRESC_W     6  width of prescale input (max 63 clks/bit)
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  rst         in   1           synchronous, active-high reset
//  p_data      in   DATA_WIDTH  byte to send, sampled on acceptance
//  data_valid  in   1           request to send p_data
//  par_en      in   1           1 = append parity bit
//  par_typ     in   1           0 = even parity, 1 = odd parity
//  prescale    in   PRESC_W     clks per bit (8 and 16 in normal use)
//  tx_out      out  1           serial line, idle high
//  busy        out  1           1 while a frame is on the line
//  frame_done  out  1           1-clk pulse after stop bit completes
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, tx_out=1, busy=0, frame_done=0, edge_cnt=0, bit_cnt=0.
//  All outputs registered. Reset mid-frame aborts: next cycle tx_out=1, busy=0, no frame_done.
//  Acceptance: data_valid=1 while state=IDLE (busy=0) latches p_data, par_en, par_typ, prescale.
//   data_valid while busy=1 is ignored (no queue); input changes after acceptance have no effect.
//  Prescale rule: latched value <4 is treated as 4; bit time = P clks.
//  States / transitions (edge_cnt counts 0..P-1 per bit, wraps to 0 at each bit boundary):
//   IDLE  : tx_out=1, busy=0. accept -> START.
//   START : tx_out=0. edge_cnt==P-1 -> DATA, bit_cnt=0.
//   DATA  : tx_out=shreg[0]; shift right at each bit end. edge_cnt==P-1 and
//           bit_cnt==DATA_WIDTH-1 -> PARITY if par_en latched, else STOP; else bit_cnt++.
//   PARITY: tx_out = ^data (even) or ~^data (odd), from latched data. edge_cnt==P-1 -> STOP.
//   STOP  : tx_out=1. edge_cnt==P-1 -> IDLE with frame_done=1 for one clk.
//  Latency: accept at cycle 0 -> start bit on tx_out cycles 1..P.
//  Frame length N = 10 bits (no parity) or 11 (parity) for DATA_WIDTH=8; busy=1 for exactly P*N clks.
//  frame_done=1 and busy=0 in cycle P*N+1; tx_out=1 that cycle.
//  Back-to-back: data_valid=1 in the frame_done cycle is accepted; next start bit begins the
//   following cycle, giving exactly one idle-high clk between frames.
//  Simultaneous rst and data_valid: rst wins, nothing accepted.
// TESTING
//  T1 reset: rst=1 2 clks, other inputs random -> tx_out=1, busy=0, frame_done=0 throughout.
//  T2 p_data=8'hA5, par_en=0, prescale=8 -> tx_out bits 0,1,0,1,0,0,1,0,1,1, 8 clks each;
//     busy=1 for 80 clks; frame_done pulse at clk 81.
//  T3 p_data=8'h07, par_en=1, prescale=16: par_typ=0 -> parity bit 1; par_typ=1 -> parity bit 0;
//     busy=1 for 176 clks each frame.
//  T4 data_valid held high, p_data 8'h55 then 8'hFF, prescale=8 -> two complete frames,
//     exactly one tx_out=1 idle clk (the frame_done clk) between stop bit and next start bit.
//  T5 data_valid pulsed with p_data=8'h3C during DATA bit 2 of frame 8'hA5 -> ignored;
//     8'hA5 frame unchanged, no second frame follows.
//  T6 rst during DATA bit 3 -> next clk tx_out=1, busy=0, no frame_done; subsequent
//     8'h81 request (prescale=8) transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller. Serializes one parallel word into
// a frame on tx_out: start(0), DATA_WIDTH data bits LSB first, optional
// parity, one stop(1). Each bit lasts `prescale` clocks (minimum 4).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   p_data, data_valid  word to send and its request strobe (taken only when idle)
//   par_en, par_typ     parity enable, parity type (0 even, 1 odd)
//   prescale            clocks per bit
//   tx_out              serial line, idle high (registered)
//   busy                high while a frame is on the line (registered)
//   frame_done          one-clock pulse after the stop bit (registered)
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESC_W-1:0]    prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned MIN_PRE = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [PRESC_W-1:0]      edge_cnt, edge_cnt_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]   shreg, shreg_nxt;
  logic [PRESC_W-1:0]      last_edge, last_edge_nxt;
  logic                    par_on, par_on_nxt;
  logic                    par_bit, par_bit_nxt;
  logic                    tx_nxt, busy_nxt, done_nxt;
  logic                    bit_end;
  logic [PRESC_W-1:0]      presc_eff;

  // Short prescale values are clamped so each bit lasts at least 4 clocks.
  assign presc_eff = (prescale < PRESC_W'(MIN_PRE)) ? PRESC_W'(MIN_PRE) : prescale;
  assign bit_end   = (edge_cnt == last_edge);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      last_edge  <= '0;
      par_on     <= 1'b0;
      par_bit    <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      edge_cnt   <= edge_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      last_edge  <= last_edge_nxt;
      par_on     <= par_on_nxt;
      par_bit    <= par_bit_nxt;
      tx_out     <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    state_nxt     = state;
    edge_cnt_nxt  = bit_end ? '0 : edge_cnt + PRESC_W'(1);
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    last_edge_nxt = last_edge;
    par_on_nxt    = par_on;
    par_bit_nxt   = par_bit;
    done_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        edge_cnt_nxt = '0;
        if (data_valid) begin
          state_nxt     = S_START;
          shreg_nxt     = p_data;
          last_edge_nxt = presc_eff - PRESC_W'(1);
          par_on_nxt    = par_en;
          // Even parity is the XOR of the data; odd parity is its complement.
          par_bit_nxt   = (^p_data) ^ par_typ;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            state_nxt = par_on ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        edge_cnt_nxt = '0;
      end
    endcase

    // Line level for the cycle that follows, derived from the next state.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg_nxt[0];
      S_PARITY: tx_nxt = par_bit_nxt;
      default:  tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized and directed stimulus for uart_tx_ctrl, checked
// every cycle against a frame-level reference model that expands each
// accepted request into its expected line schedule.
module tb_uart_tx_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;
  logic          frame_done;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: expected {frame_done, busy, tx_out} per cycle.
  logic [2:0] sched[$];
  logic [2:0] exp_o = 3'b001;

  always @(posedge clk) begin
    int p;
    logic [DW+2:0] bits;
    int nb;
    if (rst) begin
      sched.delete();
      exp_o <= 3'b001;
    end else begin
      if (!exp_o[1] && data_valid) begin
        p  = (int'(prescale) < 4) ? 4 : int'(prescale);
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < int'(DW); i++) bits[i+1] = p_data[i];
        nb = DW + 1;
        if (par_en) begin
          bits[nb] = par_typ ? ~(^p_data) : (^p_data);
          nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        for (int b = 0; b < nb; b++)
          for (int k = 0; k < p; k++) sched.push_back({1'b0, 1'b1, bits[b]});
        sched.push_back(3'b101);
      end
      if (sched.size() > 0) exp_o <= sched.pop_front();
      else                  exp_o <= 3'b001;
    end
  end

  // Compare away from the active edge.
  always @(negedge clk) begin
    chk("tx_out", 32'(tx_out), 32'(exp_o[0]));
    chk("busy", 32'(busy), 32'(exp_o[1]));
    chk("frame_done", 32'(frame_done), 32'(exp_o[2]));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    p_data   = DW'($urandom);
    par_en   = 1'($urandom);
    par_typ  = 1'($urandom);
    prescale = PW'($urandom);
  endtask

  // One-clock request; inputs are scrambled afterwards to show they are not reused.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input logic [PW-1:0] ps);
    p_data = d; par_en = pe; par_typ = pt; prescale = ps;
    data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    scramble();
  endtask

  initial begin
    // Reset with random inputs, including a request that must be dropped.
    rst = 1'b1;
    scramble();
    data_valid = 1'b1;
    cyc(2);
    rst = 1'b0;
    data_valid = 1'b0;
    cyc(3);

    // A5, no parity, 8 clks/bit
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    cyc(85);

    // 07 with even then odd parity, 16 clks/bit
    send(8'h07, 1'b1, 1'b0, 6'd16);
    cyc(180);
    send(8'h07, 1'b1, 1'b1, 6'd16);
    cyc(180);

    // Back-to-back with data_valid held high
    p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
    data_valid = 1'b1;
    cyc(1);
    p_data = 8'hFF;
    cyc(81);
    data_valid = 1'b0;
    cyc(90);

    // Request during DATA bit 2 is ignored
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    cyc(27);
    p_data = 8'h3C;
    data_valid = 1'b1;
    cyc(1);
    data_valid = 1'b0;
    cyc(60);

    // Reset during DATA bit 3, then a clean frame
    send(8'hA5, 1'b0, 1'b0, 6'd8);
    cyc(35);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    send(8'h81, 1'b0, 1'b0, 6'd8);
    cyc(85);

    // Randomized traffic, including small prescale values and stray requests
    for (int i = 0; i < 25; i++) begin
      int wait_c;
      send(DW'($urandom), 1'($urandom), 1'($urandom), PW'($urandom_range(0, 20)));
      wait_c = 0;
      while (wait_c < 240) begin
        data_valid = ($urandom_range(0, 15) == 0);
        p_data = DW'($urandom);
        rst = ($urandom_range(0, 2000) == 0);
        cyc(1);
        wait_c++;
      end
      data_valid = 1'b0;
      rst = 1'b0;
      cyc(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
